duck_flight_controller: RTL and testbench
=========================================

# duck_flight_controller

Per-frame game controller for one duck sprite in the VGA pipeline. Sits between the VGA timing generator and the duck sprite ROM: it owns the duck's position, flight direction, life state and animation frame. Every pixel clock it produces the sprite draw window and ROM address for the renderer. It also evaluates shots from the crosshair logic and keeps the hit score.

## Interface

Parameters:
- SPRITE_W, 124, sprite width in pixels
- SPRITE_H, 162, sprite height in pixels
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- X_STEP, 2, horizontal pixels moved per frame in FLY
- Y_STEP, 1, vertical pixels moved per frame in FLY
- FALL_STEP, 4, vertical pixels moved per frame in FALL
- START_X, 0, spawn column
- START_Y, 100, spawn row
- HIT_FRAMES, 30, frames held in HIT
- RESPAWN_FRAMES, 60, frames spent invisible in RESPAWN
- ANIM_DIV, 8, frames per wing-flap toggle

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  10  current column
- vcount  in  10  current row
- shoot  in  1  one-cycle trigger pulse
- cursor_x  in  10  crosshair column
- cursor_y  in  10  crosshair row
- duck_x  out  10  sprite left column
- duck_y  out  10  sprite top row
- frame_sel  out  2  animation frame: 0/1 = flap, 2 = hit, 3 = falling
- visible  out  1  duck is drawn
- state  out  2  0 = FLY, 1 = HIT, 2 = FALL, 3 = RESPAWN
- score  out  8  hits, saturating at 255
- draw  out  1  current pixel lies inside the sprite
- rom_addr  out  17  sprite ROM address

## Operation

- Frame tick:
  - one-cycle internal pulse when hcount==0 and vcount==V_ACTIVE.
  - All position, state, animation and score updates happen only on the tick.
- Shot latch:
  - set by shoot in any cycle; cleared on every tick.
  - A shoot on the tick cycle itself counts toward that tick.
- FLY:
  - At the tick, if the latch is set and cursor_x is in [duck_x, duck_x+SPRITE_W) and cursor_y is in [duck_y, duck_y+SPRITE_H):
    - go to HIT; score+1, saturating.
    - The test uses the pre-update position.
  - Otherwise, x moves by X_STEP in dir_x and y moves by Y_STEP in dir_y.
  - Clamp x to [0, H_ACTIVE-SPRITE_W] = [0, 516]; on reaching a bound, set x to the bound and flip dir_x.
  - y is handled the same way in [0, V_ACTIVE-SPRITE_H] = [0, 318], flipping dir_y.
  - frame_sel toggles between 0 and 1 every ANIM_DIV ticks.
- HIT:
  - Position frozen; frame_sel=2.
  - Stay for HIT_FRAMES ticks, then go to FALL.
- FALL:
  - frame_sel=3; y += FALL_STEP, clamped to 318.
  - On the tick where y reaches 318, go to RESPAWN.
- RESPAWN:
  - visible=0; wait RESPAWN_FRAMES ticks.
  - Then x=START_X, y=START_Y, dir_x=right, dir_y=down, frame_sel=0, anim counter=0, FLY, visible=1.
- Shots: in HIT, FALL and RESPAWN the latch is discarded without effect.
- Arithmetic:
  - All coordinate math is unsigned 11-bit internally, so no wrap.
  - Bound checks are done before adding.
- draw and rom_addr:
  - draw = visible and hcount in [duck_x, duck_x+SPRITE_W) and vcount in [duck_y, duck_y+SPRITE_H).
  - When draw=1: rom_addr = frame_sel*SPRITE_W*SPRITE_H + (vcount-duck_y)*SPRITE_W + (hcount-duck_x).
  - When draw=0: rom_addr holds 0.

## Timing

- Reset values (applied on the next clk edge, from any state, mid-frame included):
  - duck_x=START_X, duck_y=START_Y, dir right/down
  - state=FLY, frame_sel=0, visible=1, score=0
  - draw=0, rom_addr=0
  - shot latch, HIT/RESPAWN counters and anim counter = 0
- Tick updates are visible on outputs one cycle after the tick cycle.
- draw and rom_addr are registered: one cycle of latency from hcount/vcount.
- The sprite is never drawn during a tick, since vcount=V_ACTIVE is off-screen. No tearing.

## Test plan

- Reset: assert reset for 2 cycles mid-frame. Required: duck_x=0, duck_y=100, state=0, score=0, draw=0, rom_addr=0, visible=1.
- Flight and bounce:
  - 10 ticks: duck_x=20, duck_y=110.
  - Tick 258: duck_x=516.
  - Next tick: duck_x=514.
  - duck_y bounces at 318.
  - frame_sel toggles at ticks 8 and 16.
- Draw window, at (0,100), frame 0:
  - hcount=0, vcount=100: next cycle draw=1, rom_addr=0.
  - hcount=123, vcount=101: rom_addr=247.
  - hcount=124: draw=0, rom_addr=0.
- Hit:
  - At (0,100), cursor (50,150), shoot 1 cycle before the tick.
  - Required: state=1, score=1, frame_sel=2, position frozen.
  - 30 ticks later: state=2.
- Miss and ignored shots:
  - Cursor (600,10) plus shoot: state stays 0, score stays 0.
  - A shot during HIT leaves score unchanged.
  - Saturation: score at 255 plus a hit stays 255.
- Fall, respawn and mid-fall reset:
  - FALL from y=100: y=316 after 54 ticks; y=318 and state=3, visible=0 on tick 55.
  - 60 ticks later: state=0 at (0,100).
  - A reset during FALL returns all outputs to their reset values next cycle.

Source files
------------

// File: rtl/duck_flight_controller_if.sv
// Signal bundle between the raster/crosshair side and one duck sprite controller.
// The master drives raster position and shots; the slave returns sprite state and ROM address.
interface duck_flight_controller_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        shoot;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic [9:0]  duck_x;
    logic [9:0]  duck_y;
    logic [1:0]  frame_sel;
    logic        visible;
    logic [1:0]  state;
    logic [7:0]  score;
    logic        draw;
    logic [16:0] rom_addr;

    modport master (
        output hcount, vcount, shoot, cursor_x, cursor_y,
        input  duck_x, duck_y, frame_sel, visible, state, score, draw, rom_addr
    );

    modport slave (
        input  hcount, vcount, shoot, cursor_x, cursor_y,
        output duck_x, duck_y, frame_sel, visible, state, score, draw, rom_addr
    );
endinterface

// File: rtl/duck_flight_controller.sv
// Per-frame duck sprite controller: flight/bounce, shot evaluation, hit/fall/respawn
// life cycle, score keeping, and a registered sprite draw window with ROM address.
module duck_flight_controller #(
    parameter int SPRITE_W       = 124,
    parameter int SPRITE_H       = 162,
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int X_STEP         = 2,
    parameter int Y_STEP         = 1,
    parameter int FALL_STEP      = 4,
    parameter int START_X        = 0,
    parameter int START_Y        = 100,
    parameter int HIT_FRAMES     = 30,
    parameter int RESPAWN_FRAMES = 60,
    parameter int ANIM_DIV       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    duck_flight_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        FLY     = 2'd0,
        HIT     = 2'd1,
        FALL    = 2'd2,
        RESPAWN = 2'd3
    } state_t;

    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [9:0]  X_MAX10  = 10'(H_ACTIVE - SPRITE_W);
    localparam logic [9:0]  Y_MAX10  = 10'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] X_STEP11 = 11'(X_STEP);
    localparam logic [10:0] Y_STEP11 = 11'(Y_STEP);
    localparam logic [9:0]  X_STEP10 = 10'(X_STEP);
    localparam logic [9:0]  Y_STEP10 = 10'(Y_STEP);
    localparam logic [10:0] FALL11   = 11'(FALL_STEP);
    localparam logic [10:0] SPR_W11  = 11'(SPRITE_W);
    localparam logic [10:0] SPR_H11  = 11'(SPRITE_H);
    localparam logic [16:0] SPR_W17  = 17'(SPRITE_W);
    localparam logic [16:0] FRAME_SZ = 17'(SPRITE_W * SPRITE_H);
    localparam logic [9:0]  START_X10 = 10'(START_X);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);
    localparam logic [9:0]  V_TICK    = 10'(V_ACTIVE);
    localparam logic [7:0]  HIT_LAST  = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  RESP_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0]  ANIM_LAST = 8'(ANIM_DIV - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, y_q;
    logic        dir_x_q, dir_y_q;   // 1 = right / down
    logic        flap_q;
    logic [7:0]  anim_q, cnt_q, score_q;
    logic        shot_q;
    logic        draw_q;
    logic [16:0] rom_q;

    logic        tick, hit_cond, fall_end;
    logic [10:0] x_w, y_w, cx_w, cy_w, hx_w, vy_w;
    logic [10:0] x_inc, y_inc, y_fall;
    logic [9:0]  x_dec, y_dec, x_d, y_d, dx, dy;
    logic        flip_x, flip_y, in_win;
    logic [1:0]  frame_sel_c;
    logic        visible_c;
    logic [16:0] addr_c;

    assign tick = (bus.hcount == 10'd0) && (bus.vcount == V_TICK);
    assign x_w  = {1'b0, x_q};
    assign y_w  = {1'b0, y_q};
    assign cx_w = {1'b0, bus.cursor_x};
    assign cy_w = {1'b0, bus.cursor_y};
    assign hx_w = {1'b0, bus.hcount};
    assign vy_w = {1'b0, bus.vcount};

    // A shoot arriving on the tick cycle itself still counts for that tick.
    assign hit_cond = (shot_q | bus.shoot)
                    && (cx_w >= x_w) && (cx_w < x_w + SPR_W11)
                    && (cy_w >= y_w) && (cy_w < y_w + SPR_H11);

    assign x_inc    = x_w + X_STEP11;
    assign y_inc    = y_w + Y_STEP11;
    assign x_dec    = x_q - X_STEP10;
    assign y_dec    = y_q - Y_STEP10;
    assign y_fall   = y_w + FALL11;
    assign fall_end = (y_fall >= Y_MAX);

    // Bounds are tested before the step is applied, so the clamp never wraps.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        x_d    = x_q;
        y_d    = y_q;
        flip_x = 1'b0;
        flip_y = 1'b0;
        if (dir_x_q) begin
            if (x_inc >= X_MAX) begin x_d = X_MAX10; flip_x = 1'b1; end
            else                      x_d = x_inc[9:0];
        end else begin
            if (x_w <= X_STEP11) begin x_d = 10'd0; flip_x = 1'b1; end
            else                       x_d = x_dec;
        end
        if (dir_y_q) begin
            if (y_inc >= Y_MAX) begin y_d = Y_MAX10; flip_y = 1'b1; end
            else                      y_d = y_inc[9:0];
        end else begin
            if (y_w <= Y_STEP11) begin y_d = 10'd0; flip_y = 1'b1; end
            else                       y_d = y_dec;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever written with non-blocking assignments.
        if (reset) state_q <= FLY;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                FLY:     if (hit_cond)             state_d = HIT;
                HIT:     if (cnt_q == HIT_LAST)    state_d = FALL;
                FALL:    if (fall_end)             state_d = RESPAWN;
                RESPAWN: if (cnt_q == RESP_LAST)   state_d = FLY;
            endcase
        end
    end

    // Output decode
    always_comb begin
        visible_c   = 1'b1;
        frame_sel_c = {1'b0, flap_q};
        unique case (state_q)
            FLY:     ;
            HIT:     frame_sel_c = 2'd2;
            FALL:    frame_sel_c = 2'd3;
            RESPAWN: begin frame_sel_c = 2'd3; visible_c = 1'b0; end
        endcase
    end

    // Position, counters, animation and score; all change only on the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= START_X10;
            y_q     <= START_Y10;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            flap_q  <= 1'b0;
            anim_q  <= 8'd0;
            cnt_q   <= 8'd0;
            score_q <= 8'd0;
            shot_q  <= 1'b0;
        end else begin
            shot_q <= tick ? 1'b0 : (shot_q | bus.shoot);
            if (tick) begin
                unique case (state_q)
                    FLY: begin
                        if (hit_cond) begin
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        end else begin
                            x_q     <= x_d;
                            y_q     <= y_d;
                            dir_x_q <= dir_x_q ^ flip_x;
                            dir_y_q <= dir_y_q ^ flip_y;
                            if (anim_q == ANIM_LAST) begin
                                anim_q <= 8'd0;
                                flap_q <= ~flap_q;
                            end else begin
                                anim_q <= anim_q + 8'd1;
                            end
                        end
                    end
                    HIT:  cnt_q <= (cnt_q == HIT_LAST) ? 8'd0 : cnt_q + 8'd1;
                    FALL: y_q   <= fall_end ? Y_MAX10 : y_fall[9:0];
                    RESPAWN: begin
                        if (cnt_q == RESP_LAST) begin
                            cnt_q   <= 8'd0;
                            x_q     <= START_X10;
                            y_q     <= START_Y10;
                            dir_x_q <= 1'b1;
                            dir_y_q <= 1'b1;
                            flap_q  <= 1'b0;
                            anim_q  <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign in_win = visible_c
                  && (hx_w >= x_w) && (hx_w < x_w + SPR_W11)
                  && (vy_w >= y_w) && (vy_w < y_w + SPR_H11);
    assign dx     = bus.hcount - x_q;
    assign dy     = bus.vcount - y_q;
    assign addr_c = FRAME_SZ * {15'd0, frame_sel_c} + SPR_W17 * {7'd0, dy} + {7'd0, dx};

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_q <= 1'b0;
            rom_q  <= 17'd0;
        end else begin
            draw_q <= in_win;
            rom_q  <= in_win ? addr_c : 17'd0;
        end
    end

    assign bus.duck_x    = x_q;
    assign bus.duck_y    = y_q;
    assign bus.frame_sel = frame_sel_c;
    assign bus.visible   = visible_c;
    assign bus.state     = state_q;
    assign bus.score     = score_q;
    assign bus.draw      = draw_q;
    assign bus.rom_addr  = rom_q;

endmodule

// File: tb/tb_duck_flight_controller.sv
// Directed bench for duck_flight_controller: reset, flight/bounce, draw window,
// hits, misses, ignored shots, score saturation, fall/respawn and mid-fall reset.
module tb_duck_flight_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    duck_flight_controller_if bus ();

    duck_flight_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_raster();
        bus.hcount = 10'd700;
        bus.vcount = 10'd500;
    endtask

    // Hold the raster on the tick position for n consecutive cycles (n ticks).
    task automatic tick(input int n);
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        repeat (n) @(posedge clk);
        #1;
        idle_raster();
    endtask

    task automatic tick_shoot();
        bus.shoot = 1'b1;
        tick(1);
        bus.shoot = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic expect_reset_values(input string tag);
        n_checks++; if (bus.duck_x !== 10'd0) begin n_fail++; $display("FAIL %s duck_x: got %0d want 0", tag, bus.duck_x); end
        n_checks++; if (bus.duck_y !== 10'd100) begin n_fail++; $display("FAIL %s duck_y: got %0d want 100", tag, bus.duck_y); end
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL %s state: got %0d want 0", tag, bus.state); end
        n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL %s score: got %0d want 0", tag, bus.score); end
        n_checks++; if (bus.draw !== 1'b0) begin n_fail++; $display("FAIL %s draw: got %b want 0", tag, bus.draw); end
        n_checks++; if (bus.rom_addr !== 17'd0) begin n_fail++; $display("FAIL %s rom_addr: got %0d want 0", tag, bus.rom_addr); end
        n_checks++; if (bus.visible !== 1'b1) begin n_fail++; $display("FAIL %s visible: got %b want 1", tag, bus.visible); end
        n_checks++; if (bus.frame_sel !== 2'd0) begin n_fail++; $display("FAIL %s frame_sel: got %0d want 0", tag, bus.frame_sel); end
    endtask

    task automatic test_reset();
        tick(3);
        bus.cursor_x = 10'd50; bus.cursor_y = 10'd150; bus.shoot = 1'b1;
        tick(1);
        bus.shoot = 1'b0;
        // mid-frame, on a pixel inside the spawn sprite window
        bus.hcount = 10'd10; bus.vcount = 10'd110;
        reset = 1'b1;
        step(); step();
        expect_reset_values("reset");
        idle_raster();
        reset = 1'b0;
        step();
    endtask

    task automatic test_flight();
        pulse_reset();
        tick(7);
        n_checks++; if (bus.frame_sel !== 2'd0) begin n_fail++; $display("FAIL flap_t7: got %0d want 0", bus.frame_sel); end
        tick(1);
        n_checks++; if (bus.frame_sel !== 2'd1) begin n_fail++; $display("FAIL flap_t8: got %0d want 1", bus.frame_sel); end
        tick(2);
        n_checks++; if (bus.duck_x !== 10'd20) begin n_fail++; $display("FAIL fly_x_t10: got %0d want 20", bus.duck_x); end
        n_checks++; if (bus.duck_y !== 10'd110) begin n_fail++; $display("FAIL fly_y_t10: got %0d want 110", bus.duck_y); end
        tick(5);
        n_checks++; if (bus.frame_sel !== 2'd1) begin n_fail++; $display("FAIL flap_t15: got %0d want 1", bus.frame_sel); end
        tick(1);
        n_checks++; if (bus.frame_sel !== 2'd0) begin n_fail++; $display("FAIL flap_t16: got %0d want 0", bus.frame_sel); end
        tick(202);
        n_checks++; if (bus.duck_y !== 10'd318) begin n_fail++; $display("FAIL bounce_y_t218: got %0d want 318", bus.duck_y); end
        n_checks++; if (bus.duck_x !== 10'd436) begin n_fail++; $display("FAIL fly_x_t218: got %0d want 436", bus.duck_x); end
        tick(1);
        n_checks++; if (bus.duck_y !== 10'd317) begin n_fail++; $display("FAIL bounce_y_t219: got %0d want 317", bus.duck_y); end
        tick(39);
        n_checks++; if (bus.duck_x !== 10'd516) begin n_fail++; $display("FAIL bounce_x_t258: got %0d want 516", bus.duck_x); end
        n_checks++; if (bus.duck_y !== 10'd278) begin n_fail++; $display("FAIL fly_y_t258: got %0d want 278", bus.duck_y); end
        tick(1);
        n_checks++; if (bus.duck_x !== 10'd514) begin n_fail++; $display("FAIL bounce_x_t259: got %0d want 514", bus.duck_x); end
        n_checks++; if (bus.duck_y !== 10'd277) begin n_fail++; $display("FAIL fly_y_t259: got %0d want 277", bus.duck_y); end
    endtask

    task automatic test_draw();
        pulse_reset();
        bus.hcount = 10'd0; bus.vcount = 10'd100;
        step();
        n_checks++; if (bus.draw !== 1'b1) begin n_fail++; $display("FAIL draw_corner: got %b want 1", bus.draw); end
        n_checks++; if (bus.rom_addr !== 17'd0) begin n_fail++; $display("FAIL rom_corner: got %0d want 0", bus.rom_addr); end
        bus.hcount = 10'd123; bus.vcount = 10'd101;
        step();
        n_checks++; if (bus.rom_addr !== 17'd247) begin n_fail++; $display("FAIL rom_right_edge: got %0d want 247", bus.rom_addr); end
        bus.hcount = 10'd124;
        step();
        n_checks++; if (bus.draw !== 1'b0) begin n_fail++; $display("FAIL draw_past_right: got %b want 0", bus.draw); end
        n_checks++; if (bus.rom_addr !== 17'd0) begin n_fail++; $display("FAIL rom_past_right: got %0d want 0", bus.rom_addr); end
        bus.hcount = 10'd5; bus.vcount = 10'd99;
        step();
        n_checks++; if (bus.draw !== 1'b0) begin n_fail++; $display("FAIL draw_above_top: got %b want 0", bus.draw); end
        bus.hcount = 10'd0; bus.vcount = 10'd261;
        step();
        n_checks++; if (bus.rom_addr !== 17'd19964) begin n_fail++; $display("FAIL rom_bottom_row: got %0d want 19964", bus.rom_addr); end
        bus.vcount = 10'd262;
        step();
        n_checks++; if (bus.draw !== 1'b0) begin n_fail++; $display("FAIL draw_below_bottom: got %b want 0", bus.draw); end
        // after 8 ticks the duck sits at (16,108) showing flap frame 1
        idle_raster();
        tick(8);
        bus.hcount = 10'd21; bus.vcount = 10'd110;
        step();
        n_checks++; if (bus.rom_addr !== 17'd20341) begin n_fail++; $display("FAIL rom_frame1: got %0d want 20341", bus.rom_addr); end
        idle_raster();
        step();
    endtask

    task automatic test_hit_fall_respawn();
        pulse_reset();
        bus.cursor_x = 10'd50; bus.cursor_y = 10'd150;
        bus.shoot = 1'b1;
        step();
        bus.shoot = 1'b0;
        tick(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL hit_state: got %0d want 1", bus.state); end
        n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL hit_score: got %0d want 1", bus.score); end
        n_checks++; if (bus.frame_sel !== 2'd2) begin n_fail++; $display("FAIL hit_frame: got %0d want 2", bus.frame_sel); end
        n_checks++; if (bus.duck_x !== 10'd0 || bus.duck_y !== 10'd100) begin n_fail++; $display("FAIL hit_frozen: got (%0d,%0d) want (0,100)", bus.duck_x, bus.duck_y); end
        tick_shoot();
        n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL shot_in_hit: got %0d want 1", bus.score); end
        tick(28);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL hit_hold_29: got %0d want 1", bus.state); end
        tick(1);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL hit_to_fall: got %0d want 2", bus.state); end
        n_checks++; if (bus.frame_sel !== 2'd3) begin n_fail++; $display("FAIL fall_frame: got %0d want 3", bus.frame_sel); end
        tick(54);
        n_checks++; if (bus.duck_y !== 10'd316) begin n_fail++; $display("FAIL fall_y_54: got %0d want 316", bus.duck_y); end
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL fall_state_54: got %0d want 2", bus.state); end
        tick(1);
        n_checks++; if (bus.duck_y !== 10'd318) begin n_fail++; $display("FAIL fall_y_55: got %0d want 318", bus.duck_y); end
        n_checks++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL respawn_state: got %0d want 3", bus.state); end
        n_checks++; if (bus.visible !== 1'b0) begin n_fail++; $display("FAIL respawn_visible: got %b want 0", bus.visible); end
        tick(59);
        n_checks++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL respawn_hold_59: got %0d want 3", bus.state); end
        tick(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL respawn_fly: got %0d want 0", bus.state); end
        n_checks++; if (bus.duck_x !== 10'd0 || bus.duck_y !== 10'd100) begin n_fail++; $display("FAIL respawn_pos: got (%0d,%0d) want (0,100)", bus.duck_x, bus.duck_y); end
        n_checks++; if (bus.visible !== 1'b1 || bus.frame_sel !== 2'd0) begin n_fail++; $display("FAIL respawn_vis_frame: got vis=%b fs=%0d want 1/0", bus.visible, bus.frame_sel); end
        n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL respawn_score: got %0d want 1", bus.score); end
    endtask

    task automatic test_miss_and_mid_fall_reset();
        pulse_reset();
        bus.cursor_x = 10'd600; bus.cursor_y = 10'd10;
        tick_shoot();
        n_checks++; if (bus.state !== 2'd0 || bus.score !== 8'd0) begin n_fail++; $display("FAIL miss_far: got state=%0d score=%0d want 0/0", bus.state, bus.score); end
        n_checks++; if (bus.duck_x !== 10'd2 || bus.duck_y !== 10'd101) begin n_fail++; $display("FAIL miss_moves: got (%0d,%0d) want (2,101)", bus.duck_x, bus.duck_y); end
        // latch was cleared by the previous tick, so no shot this time
        bus.cursor_x = 10'd50; bus.cursor_y = 10'd150;
        tick(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL latch_cleared: got %0d want 0", bus.state); end
        bus.cursor_x = 10'd128; bus.cursor_y = 10'd150;
        tick_shoot();
        n_checks++; if (bus.state !== 2'd0 || bus.score !== 8'd0) begin n_fail++; $display("FAIL miss_right_edge: got state=%0d score=%0d want 0/0", bus.state, bus.score); end
        bus.cursor_x = 10'd129; bus.cursor_y = 10'd264;
        tick_shoot();
        n_checks++; if (bus.state !== 2'd1 || bus.score !== 8'd1) begin n_fail++; $display("FAIL hit_far_corner: got state=%0d score=%0d want 1/1", bus.state, bus.score); end
        n_checks++; if (bus.duck_x !== 10'd6 || bus.duck_y !== 10'd103) begin n_fail++; $display("FAIL hit_corner_pos: got (%0d,%0d) want (6,103)", bus.duck_x, bus.duck_y); end
        tick(35);
        n_checks++; if (bus.state !== 2'd2 || bus.duck_y !== 10'd123) begin n_fail++; $display("FAIL midfall: got state=%0d y=%0d want 2/123", bus.state, bus.duck_y); end
        bus.hcount = 10'd10; bus.vcount = 10'd110;
        reset = 1'b1;
        step();
        expect_reset_values("midfall_reset");
        reset = 1'b0;
        step();
        n_checks++; if (bus.rom_addr !== 17'd1250) begin n_fail++; $display("FAIL post_reset_draw: got %0d want 1250", bus.rom_addr); end
        idle_raster();
        step();
    endtask

    task automatic test_saturation();
        pulse_reset();
        bus.cursor_x = 10'd50; bus.cursor_y = 10'd150;
        for (int i = 0; i < 255; i++) begin
            tick_shoot();
            tick(145);
        end
        n_checks++; if (bus.score !== 8'd255) begin n_fail++; $display("FAIL score_255: got %0d want 255", bus.score); end
        n_checks++; if (bus.state !== 2'd0 || bus.duck_x !== 10'd0 || bus.duck_y !== 10'd100) begin n_fail++; $display("FAIL sat_respawned: got state=%0d (%0d,%0d) want 0 (0,100)", bus.state, bus.duck_x, bus.duck_y); end
        tick_shoot();
        n_checks++; if (bus.state !== 2'd1 || bus.score !== 8'd255) begin n_fail++; $display("FAIL score_saturate: got state=%0d score=%0d want 1/255", bus.state, bus.score); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.shoot    = 1'b0;
        bus.cursor_x = 10'd0;
        bus.cursor_y = 10'd0;
        idle_raster();
        step(); step();
        reset = 1'b0;
        step();

        test_reset();
        test_flight();
        test_draw();
        test_hit_fall_respawn();
        test_miss_and_mid_fall_reset();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
